// File: rtl/net_force_ctrl.sv
// Registered net driver with synthesizable force/release override.
// Optional auto-release timer built when FORCE_TIMEOUT_EN is defined.
module net_force_ctrl #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] drv_value,
    input  logic             force_req,
    input  logic [WIDTH-1:0] force_value,
    input  logic             release_req,
    output logic [WIDTH-1:0] net_out,
    output logic             forced,
    output logic             force_ack,
    output logic             released,
    output logic             timeout_flag
);

    typedef enum logic [1:0] {IDLE, FORCED, RELEASE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] latched, latched_nx, net_nx;
    logic             forced_nx, ack_nx, rel_nx;
    logic             timed_out;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("net_force_ctrl: TIMEOUT must be in 2..255");
    end

    always_comb begin
        state_nx   = state;
        latched_nx = latched;
        net_nx     = drv_value;
        forced_nx  = 1'b0;
        ack_nx     = 1'b0;
        rel_nx     = 1'b0;
        case (state)
            FORCED: begin
                if (release_req) begin
                    state_nx = RELEASE;
                    rel_nx   = 1'b1;
                end else if (force_req) begin
                    latched_nx = force_value;
                    net_nx     = force_value;
                    forced_nx  = 1'b1;
                    ack_nx     = 1'b1;
                end else if (timed_out) begin
                    state_nx = RELEASE;
                    rel_nx   = 1'b1;
                end else begin
                    net_nx    = latched;
                    forced_nx = 1'b1;
                end
            end
            default: begin
                // IDLE and RELEASE both accept a force; release_req is ignored here
                if (force_req) begin
                    state_nx   = FORCED;
                    latched_nx = force_value;
                    net_nx     = force_value;
                    forced_nx  = 1'b1;
                    ack_nx     = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            latched   <= '0;
            net_out   <= '0;
            forced    <= 1'b0;
            force_ack <= 1'b0;
            released  <= 1'b0;
        end else begin
            state     <= state_nx;
            latched   <= latched_nx;
            net_out   <= net_nx;
            forced    <= forced_nx;
            force_ack <= ack_nx;
            released  <= rel_nx;
        end
    end

`ifdef FORCE_TIMEOUT_EN
    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    logic [7:0] cnt;
    logic       auto_rel;

    assign timed_out = (cnt == CNT_MAX);
    assign auto_rel  = (state == FORCED) && !release_req && !force_req && timed_out;

    // Counter holds the number of edges since the force was accepted, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= 8'd0;
            timeout_flag <= 1'b0;
        end else if (ack_nx) begin
            cnt          <= 8'd0;
            timeout_flag <= 1'b0;
        end else begin
            if (auto_rel) timeout_flag <= 1'b1;
            if (state == FORCED && cnt != CNT_MAX) cnt <= cnt + 8'd1;
        end
    end
`else
    assign timed_out    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: doc/net_force_ctrl.md
# net_force_ctrl

- Registered driver stage that sources a WIDTH-bit net and overrides it on request.
- Models procedural force/release in synthesizable form: a downstream consumer samples `net_out` and must see the normal value, a forced value, or the normal value again after release, each on a defined cycle.
- Sits directly upstream of the release-checking logic and feeds it the net under test.
- An optional timer auto-releases a force that is held too long.

## Interface
Parameters:
- `WIDTH`, 4, width of the driven net.
- `TIMEOUT`, 15, cycles a force may stay active before auto-release (range 2..255).

Ports:
- `clk`  input  1  the single clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `drv_value`  input  WIDTH  normal driver value.
- `force_req`  input  1  request to force; sampled each cycle.
- `force_value`  input  WIDTH  value to force; latched when a force is accepted.
- `release_req`  input  1  request to release the active force.
- `net_out`  output  WIDTH  registered net value.
- `forced`  output  1  high while the net is overridden.
- `force_ack`  output  1  one-cycle pulse when a force is accepted.
- `released`  output  1  one-cycle pulse on the cycle `net_out` returns to the driver value.
- `timeout_flag`  output  1  sticky; set by auto-release, cleared by the next accepted force.

## Operation
- States: IDLE, FORCED, RELEASE. Reset state is IDLE.
- Reset values: `net_out`=0, `forced`=0, `force_ack`=0, `released`=0, `timeout_flag`=0, counter=0.
- IDLE:
  - `net_out` <= `drv_value`.
  - `force_req`=1: latch `force_value`, go to FORCED, pulse `force_ack`, clear counter and `timeout_flag`.
  - `release_req` is ignored in IDLE, including when it arrives with `force_req`; the force is accepted.
- FORCED:
  - `net_out` <= latched value; `drv_value` changes are ignored; `forced`=1.
  - The counter increments each cycle and saturates at TIMEOUT-1.
  - `release_req`=1: go to RELEASE. Release wins over a simultaneous `force_req`.
  - `force_req`=1 without `release_req`: re-latch `force_value`, restart the counter, pulse `force_ack`, stay in FORCED.
  - Counter reaches TIMEOUT-1 with no request: auto-release, go to RELEASE, set `timeout_flag`.
- RELEASE (exactly one cycle):
  - `net_out` <= `drv_value`; `released` pulses; `forced`=0.
  - Next state is IDLE.
  - A `force_req` seen in RELEASE is accepted and goes straight to FORCED, so the IDLE cycle is skipped.
- Counter width is 8 bits; it never wraps.
- Reset asserted in any state returns all outputs to reset values immediately, without waiting for a clock edge. The latched value is discarded.

## Timing
- Latency: `net_out` reflects `drv_value` or `force_value` one clock after sampling. All outputs are registered.
- `force_ack` is high in the cycle in which `net_out` first shows the forced value.
- `released` is high in the cycle in which `net_out` first shows the driver value after a force.
- Auto-release: with the force accepted at edge N, `net_out` returns to the driver value at edge N+TIMEOUT.
- After `rst_n` deasserts, the first edge loads `drv_value`.

## Configuration
- `FORCE_TIMEOUT_EN` defined: the counter and auto-release are built; `timeout_flag` operates as above.
- `FORCE_TIMEOUT_EN` undefined:
  - No counter is built; a force holds indefinitely until `release_req`.
  - `timeout_flag` is tied to 0.
  - The `TIMEOUT` parameter is unused.

## Test plan
- Reset with `drv_value`=4'h5, then deassert `rst_n` -> `net_out`=0 during reset; `net_out`=4'h5 one edge after deassert; `forced`=0.
- `force_req` with `force_value`=4'hA, then `drv_value` stepped to 4'h3 -> `force_ack` pulse, `net_out`=4'hA held, `forced`=1.
- `release_req` 3 cycles after the force, `drv_value`=4'h5 -> one-cycle `released`, `net_out`=4'h5 one edge later, state IDLE.
- `force_req` and `release_req` together in FORCED -> release wins; `net_out` returns to `drv_value`; no `force_ack`.
- With `FORCE_TIMEOUT_EN`: force 4'hC and hold with no requests -> `net_out` returns to `drv_value` exactly 15 edges after acceptance; `timeout_flag`=1 until the next force. Without the macro, `net_out` stays 4'hC for 100 cycles.
- Assert `rst_n` low mid-FORCED (between edges) -> `net_out`=0 and `forced`=0 immediately. After release from reset, `net_out` follows `drv_value`, not the old forced value.
